// File: rtl/alu_pkg.sv
// Shared constants and types for the accumulator execute stage.
package alu_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned SEL_W_DEF   = 12;
    localparam int unsigned SHAMT_W_DEF = 4;

    // Bit positions within the one-hot select from the opcode decoder
    localparam int unsigned SEL_AND     = 0;
    localparam int unsigned SEL_OR      = 1;
    localparam int unsigned SEL_NOT     = 2;
    localparam int unsigned SEL_XOR     = 3;
    localparam int unsigned SEL_NAND    = 4;
    localparam int unsigned SEL_NOR     = 5;
    localparam int unsigned SEL_XNOR    = 6;
    localparam int unsigned SEL_ADD     = 7;
    localparam int unsigned SEL_SUB     = 8;
    localparam int unsigned SEL_SHRIGHT = 9;
    localparam int unsigned SEL_SHLEFT  = 10;
    localparam int unsigned SEL_CLEAR   = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_comb_unit.sv
// Combinational single-cycle result, carry and overflow for the accumulator.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] res_c,
    output logic             carry_c,
    output logic             ovf_c,
    output logic             legal_c
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, b};
    assign diff = {1'b0, acc} - {1'b0, b};

    // Exactly one select bit set
    assign legal_c = (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0);

    always_comb begin
        res_c   = acc;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (1'b1)
            sel[SEL_AND]:   res_c = acc & b;
            sel[SEL_OR]:    res_c = acc | b;
            sel[SEL_NOT]:   res_c = ~acc;
            sel[SEL_XOR]:   res_c = acc ^ b;
            sel[SEL_NAND]:  res_c = ~(acc & b);
            sel[SEL_NOR]:   res_c = ~(acc | b);
            sel[SEL_XNOR]:  res_c = ~(acc ^ b);
            sel[SEL_ADD]: begin
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ovf_c   = (acc[MSB] == b[MSB]) && (sum[MSB] != acc[MSB]);
            end
            sel[SEL_SUB]: begin
                res_c   = diff[WIDTH-1:0];
                carry_c = diff[WIDTH];
                ovf_c   = (acc[MSB] != b[MSB]) && (diff[MSB] != acc[MSB]);
            end
            sel[SEL_CLEAR]: res_c = '0;
            default:        res_c = acc;
        endcase
    end

endmodule

// File: rtl/alu_accum_exec.sv
// Accumulator execute stage: single-cycle ops plus iterative 1-bit-per-clock shifts.
module alu_accum_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_out,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int unsigned MSB = WIDTH - 1;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [SHAMT_W-1:0] cnt_q,       cnt_d;
    logic               dir_left_q,  dir_left_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               flag_z_q,    flag_z_d;
    logic               flag_c_q,    flag_c_d;
    logic               flag_v_q,    flag_v_d;
    logic               flag_err_q,  flag_err_d;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_carry;
    logic               comb_ovf;
    logic               comb_legal;

    logic               accept;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic               step_left;
    logic [WIDTH-1:0]   step_res;
    logic               step_out;

    alu_comb_unit #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_comb (
        .acc     (acc_q),
        .b       (b),
        .sel     (sel),
        .res_c   (comb_res),
        .carry_c (comb_carry),
        .ovf_c   (comb_ovf),
        .legal_c (comb_legal)
    );

    assign accept   = in_valid && in_ready_q;
    assign is_shift = sel[SEL_SHRIGHT] || sel[SEL_SHLEFT];
    assign shamt    = b[SHAMT_W-1:0];

    // One-bit logical shift step; direction latched while iterating
    always_comb begin
        step_left = (state_q == IDLE) ? sel[SEL_SHLEFT] : dir_left_q;
        if (step_left) begin
            step_res = {acc_q[WIDTH-2:0], 1'b0};
            step_out = acc_q[MSB];
        end else begin
            step_res = {1'b0, acc_q[WIDTH-1:1]};
            step_out = acc_q[0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dir_left_d  = dir_left_q;
        out_valid_d = 1'b0;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        flag_err_d  = flag_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!comb_legal) begin
                        out_valid_d = 1'b1;
                        flag_c_d    = 1'b0;
                        flag_v_d    = 1'b0;
                        flag_err_d  = 1'b1;
                    end else if (is_shift) begin
                        flag_v_d   = 1'b0;
                        flag_err_d = 1'b0;
                        if (shamt == '0) begin
                            out_valid_d = 1'b1;
                            flag_c_d    = 1'b0;
                        end else begin
                            acc_d      = step_res;
                            cnt_d      = shamt - SHAMT_W'(1);
                            dir_left_d = sel[SEL_SHLEFT];
                            if (shamt == SHAMT_W'(1)) begin
                                out_valid_d = 1'b1;
                                flag_c_d    = step_out;
                            end else begin
                                state_d = SHIFT;
                            end
                        end
                    end else begin
                        acc_d       = comb_res;
                        out_valid_d = 1'b1;
                        flag_c_d    = comb_carry;
                        flag_v_d    = comb_ovf;
                        flag_err_d  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                acc_d = step_res;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    flag_c_d    = step_out;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero flag always reflects the accumulator as it will be after this result
        if (out_valid_d) begin
            flag_z_d = (acc_d == '0);
        end
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dir_left_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dir_left_q  <= dir_left_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            flag_err_q  <= flag_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_err  = flag_err_q;

endmodule
